// File: rtl/dino_jump_ctrl_pkg.sv
// Shared constants and types for the dino game: jump controller states,
// playfield rows and sprite geometry used by renderer, obstacles and physics.
package dino_jump_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_FROZEN = 2'd2
  } jump_state_t;

  // Foot-row width (half-res vertical space 0..239) and the signed width
  // used for the next-position arithmetic.
  localparam int POS_W = 9;
  localparam int NXT_W = 10;

  localparam int DINO_GROUND_Y = 200;
  localparam int DINO_CEIL_Y   = 28;
  localparam int DINO_HEIGHT   = 28;
  localparam int DINO_X        = 40;

  localparam int TICK_DIV_DEF  = 1666667;
  localparam int JUMP_V_DEF    = 12;
  localparam int GRAVITY_DEF   = 1;

  // Velocity is 8-bit signed for normal launch speeds; a launch speed that
  // does not fit in 8 bits widens it to the full next-position width so the
  // ceiling clamp still sees the true overshoot.
  function automatic int vel_width(input int jump_v);
    return (jump_v > 127) ? NXT_W : 8;
  endfunction

endpackage

// File: rtl/dino_jump_ctrl_frame_tick_gen.sv
// Frame tick generator: single-cycle strobe every TICK_DIV clocks.
// Free-running; shared by the jump controller and the obstacle scroller.
module frame_tick_gen
  import dino_jump_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; the strobe marks the last count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino jump controller: turns the jump button into a vertical foot position.
// Physics advances once per frame tick, so pos is stable for a whole frame.
// game_over freezes motion (remembering ground/air); restart returns to ground.
module dino_jump_ctrl
  import dino_jump_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int GROUND_Y = DINO_GROUND_Y,
  parameter int CEIL_Y   = DINO_CEIL_Y,
  parameter int JUMP_V   = JUMP_V_DEF,
  parameter int GRAVITY  = GRAVITY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump,
  input  logic             game_over,
  input  logic             restart,
  output logic [POS_W-1:0] pos,
  output logic             airborne,
  output logic             landed
);

  localparam int VEL_W = vel_width(JUMP_V);

  localparam logic        [POS_W-1:0] GROUND_POS = POS_W'(GROUND_Y);
  localparam logic        [POS_W-1:0] CEIL_POS   = POS_W'(CEIL_Y);
  localparam logic signed [NXT_W-1:0] GROUND_CMP = NXT_W'(GROUND_Y);
  localparam logic signed [NXT_W-1:0] CEIL_CMP   = NXT_W'(CEIL_Y);
  localparam logic signed [VEL_W-1:0] LAUNCH_VEL = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0] GRAV_STEP  = VEL_W'(GRAVITY);

  jump_state_t state, state_nxt;
  jump_state_t prior, prior_nxt;

  logic signed [VEL_W-1:0] vel, vel_nxt;
  logic        [POS_W-1:0] pos_nxt;
  logic signed [NXT_W-1:0] pos_ext, vel_ext, nxt;

  logic tick;
  logic jump_q, rise;
  logic jump_req, jump_req_nxt;
  logic launch, land;
  logic land_pend;
  logic airborne_nxt;

  frame_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Candidate position for this tick, computed in signed 10-bit space so an
  // overshoot above row 0 stays negative and compares correctly.
  assign pos_ext = $signed({1'b0, pos});
  assign vel_ext = NXT_W'(vel);
  assign nxt     = pos_ext - vel_ext;

  assign rise = jump & ~jump_q;

  // State register: current state plus the state to resume after a freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_GROUND;
      prior <= ST_GROUND;
    end else begin
      state <= state_nxt;
      prior <= prior_nxt;
    end
  end

  // Next-state logic; priority restart > game_over > landing > launch.
  always_comb begin
    state_nxt = state;
    prior_nxt = prior;
    launch    = 1'b0;
    land      = 1'b0;
    if (restart) begin
      state_nxt = ST_GROUND;
      prior_nxt = ST_GROUND;
    end else if (game_over) begin
      state_nxt = ST_FROZEN;
      if (state != ST_FROZEN) begin
        prior_nxt = state;
      end
    end else begin
      case (state)
        ST_GROUND: begin
          if (tick && jump_req) begin
            state_nxt = ST_AIR;
            launch    = 1'b1;
          end
        end
        ST_AIR: begin
          if (tick && (nxt >= GROUND_CMP)) begin
            state_nxt = ST_GROUND;
            land      = 1'b1;
          end
        end
        ST_FROZEN: begin
          state_nxt = prior;
        end
        default: begin
          state_nxt = ST_GROUND;
        end
      endcase
    end
  end

  // Output / datapath logic: position, velocity, pending jump and airborne flag.
  always_comb begin
    pos_nxt      = pos;
    vel_nxt      = vel;
    jump_req_nxt = jump_req;
    if (restart) begin
      pos_nxt = GROUND_POS;
      vel_nxt = '0;
    end else if (launch) begin
      vel_nxt = LAUNCH_VEL;
    end else if (!game_over && (state == ST_AIR) && tick) begin
      if (nxt >= GROUND_CMP) begin
        pos_nxt = GROUND_POS;
        vel_nxt = '0;
      end else if (nxt < CEIL_CMP) begin
        pos_nxt = CEIL_POS;
        vel_nxt = '0;
      end else begin
        pos_nxt = nxt[POS_W-1:0];
        vel_nxt = vel - GRAV_STEP;
      end
    end

    // A rise only counts while standing on the ground; airborne presses are
    // dropped so there is no double jump.
    if (restart || game_over || launch) begin
      jump_req_nxt = 1'b0;
    end else if (rise && (state == ST_GROUND)) begin
      jump_req_nxt = 1'b1;
    end

    airborne_nxt = (state_nxt == ST_AIR) ||
                   ((state_nxt == ST_FROZEN) && (prior_nxt == ST_AIR));
  end

  // Datapath registers; landed trails the landing tick edge by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos       <= GROUND_POS;
      vel       <= '0;
      jump_q    <= 1'b0;
      jump_req  <= 1'b0;
      land_pend <= 1'b0;
      landed    <= 1'b0;
      airborne  <= 1'b0;
    end else begin
      pos       <= pos_nxt;
      vel       <= vel_nxt;
      jump_q    <= jump;
      jump_req  <= jump_req_nxt;
      land_pend <= land;
      landed    <= land_pend & ~restart;
      airborne  <= airborne_nxt;
    end
  end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl with a 4-clock frame tick.
// A second instance uses an oversized launch speed to exercise the ceiling clamp.
module tb_dino_jump_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       jump = 1'b0;
  logic       game_over = 1'b0;
  logic       restart = 1'b0;
  logic [8:0] pos;
  logic       airborne;
  logic       landed;

  logic       jump_hv = 1'b0;
  logic       game_over_hv = 1'b0;
  logic       restart_hv = 1'b0;
  logic [8:0] pos_hv;
  logic       airborne_hv;
  logic       landed_hv;

  int checks = 0;
  int failures = 0;
  int land_cnt = 0;
  int base = 0;

  // Hand-computed default trajectory: index 0 is the launch tick.
  int traj [26] = '{200, 188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122,
                    122, 123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};
  // JUMP_V=200: clamp at 28, hold one tick, then free fall back to ground.
  int traj_hv [22] = '{200, 28, 28, 29, 31, 34, 38, 43, 49, 56, 64, 73, 83, 94,
                       106, 119, 133, 148, 164, 181, 199, 200};

  dino_jump_ctrl #(
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .jump      (jump),
    .game_over (game_over),
    .restart   (restart),
    .pos       (pos),
    .airborne  (airborne),
    .landed    (landed)
  );

  dino_jump_ctrl #(
    .TICK_DIV (4),
    .JUMP_V   (200)
  ) dut_hv (
    .clk       (clk),
    .rst       (rst),
    .jump      (jump_hv),
    .game_over (game_over_hv),
    .restart   (restart_hv),
    .pos       (pos_hv),
    .airborne  (airborne_hv),
    .landed    (landed_hv)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (landed === 1'b1) land_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full flight from a tick-aligned ground point; optionally re-press mid-air.
  task automatic fly(input string tag, input bit repress);
    int b;
    b = land_cnt;
    jump = 1'b1;
    clk_n(4);
    check({tag, "_launch_pos"}, pos, 200);
    check({tag, "_launch_air"}, airborne, 1);
    jump = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      if (repress && i == 6) jump = 1'b1;
      if (i == 3) begin
        clk_n(2);
        check({tag, "_stable_mid_tick"}, pos, traj[2]);
        clk_n(2);
      end else begin
        clk_n(4);
      end
      check($sformatf("%s_pos_t%0d", tag, i), pos, traj[i]);
      check($sformatf("%s_air_t%0d", tag, i), airborne, (i < 25) ? 1 : 0);
    end
    check({tag, "_landed_at_edge"}, landed, 0);
    clk_n(1);
    check({tag, "_landed_pulse"}, landed, 1);
    clk_n(1);
    check({tag, "_landed_clear"}, landed, 0);
    clk_n(2);
    check({tag, "_landed_count"}, land_cnt - b, 1);
    clk_n(12);
    check({tag, "_no_relaunch_pos"}, pos, 200);
    check({tag, "_no_relaunch_air"}, airborne, 0);
    jump = 1'b0;
    clk_n(4);
  endtask

  initial begin
    // Power-on reset takes effect without a clock edge.
    #3 rst = 1'b0;
    #1;
    check("por_pos", pos, 200);
    check("por_air", airborne, 0);
    check("por_landed", landed, 0);
    check("por_pos_hv", pos_hv, 200);
    clk_n(2);
    rst = 1'b1;
    clk_n(8);
    check("idle_pos", pos, 200);
    check("idle_air", airborne, 0);

    // Normal jump, then jump re-pressed mid-flight.
    fly("jump", 1'b0);
    fly("repress", 1'b1);

    // Freeze mid-flight at 143 for 10 ticks, with jump presses while frozen.
    base = land_cnt;
    jump = 1'b1;
    clk_n(4);
    jump = 1'b0;
    for (int i = 1; i <= 6; i++) clk_n(4);
    check("frz_start_pos", pos, 143);
    game_over = 1'b1;
    clk_n(1);
    check("frz_pos", pos, 143);
    check("frz_air", airborne, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 6) jump = 1'b1;
      if (i == 4 || i == 7) jump = 1'b0;
      clk_n(4);
      check($sformatf("frz_hold_%0d", i), pos, 143);
    end
    game_over = 1'b0;
    clk_n(1);
    check("frz_release_pos", pos, 143);
    check("frz_release_air", airborne, 1);
    clk_n(2);
    check("frz_resume_pos", pos, 137);
    for (int i = 8; i <= 25; i++) begin
      clk_n(4);
      check($sformatf("frz_pos_t%0d", i), pos, traj[i]);
    end
    clk_n(12);
    check("frz_no_relaunch", pos, 200);
    check("frz_landed_count", land_cnt - base, 1);

    // restart and game_over together while airborne.
    base = land_cnt;
    jump = 1'b1;
    clk_n(4);
    jump = 1'b0;
    clk_n(12);
    check("rst_go_pre_pos", pos, 167);
    restart = 1'b1;
    game_over = 1'b1;
    clk_n(1);
    restart = 1'b0;
    game_over = 1'b0;
    check("rst_go_pos", pos, 200);
    check("rst_go_air", airborne, 0);
    check("rst_go_landed", landed, 0);
    clk_n(11);
    check("rst_go_hold_pos", pos, 200);
    check("rst_go_hold_air", airborne, 0);
    check("rst_go_no_landed", land_cnt - base, 0);

    // Oversized launch speed: ceiling clamp then fall.
    jump_hv = 1'b1;
    clk_n(4);
    check("hv_launch_pos", pos_hv, 200);
    check("hv_launch_air", airborne_hv, 1);
    jump_hv = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      clk_n(4);
      check($sformatf("hv_pos_t%0d", i), pos_hv, traj_hv[i]);
      check($sformatf("hv_air_t%0d", i), airborne_hv, (i < 21) ? 1 : 0);
    end
    clk_n(1);
    check("hv_landed_pulse", landed_hv, 1);
    clk_n(3);

    // Asynchronous reset mid-flight.
    jump = 1'b1;
    clk_n(4);
    jump = 1'b0;
    clk_n(20);
    check("arst_pre_pos", pos, 150);
    check("arst_pre_air", airborne, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_pos", pos, 200);
    check("arst_air", airborne, 0);
    check("arst_landed", landed, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    clk_n(8);
    check("arst_after_pos", pos, 200);
    check("arst_after_air", airborne, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
